adc_serial_reader: RTL and testbench



---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_shift_rx.sv | 20 ++
 rtl/adc_serial_reader.sv | 111 +++++++++++
 tb/tb_adc_serial_reader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the AD7476-class serial ADC read-out path:
// controller state encoding, default frame geometry and the nominal ADC clock rate.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        QUIET = 3'd4
    } state_t;

    localparam int DEF_DATA_W     = 12;
    localparam int DEF_FRAME_BITS = 16;
    localparam int CLK_ADC_HZ     = 3200;

endpackage

// File: rtl/adc_shift_rx.sv
// Serial-in, parallel-out receive register for one ADC frame, MSB arriving first.
module adc_shift_rx
    import adc_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS
) (
    input  logic                  clk,
    input  logic                  shift_en,
    input  logic                  din,
    output logic [FRAME_BITS-1:0] q
);

    // Contents are fully overwritten by every frame, so no reset is needed.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            q <= {q[FRAME_BITS-2:0], din};
        end
    end

endmodule

// File: rtl/adc_serial_reader.sv
// Read-out controller for a 12-bit SPI-style ADC: generates cs_n/sclk, collects one
// frame per conversion and presents the sample with a one-cycle valid strobe.
module adc_serial_reader
    import adc_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int QUIET_CYC  = 2
) (
    input  logic              Clock_ADC,
    input  logic              reset_Clock,
    input  logic              enable,
    input  logic              sdata,
    output logic              cs_n,
    output logic              sclk,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int BW = $clog2(FRAME_BITS) + 1;
    localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

    state_t                state;
    logic [BW-1:0]         bit_cnt;
    logic                  phase;
    logic [QW-1:0]         quiet_cnt;
    logic                  shift_en;
    logic [FRAME_BITS-1:0] shift_q;

    // Sample on the same edge that raises sclk, one full cycle after the falling edge.
    assign shift_en = (state == SHIFT) && phase;
    assign busy     = (state != IDLE);

    adc_shift_rx #(
        .FRAME_BITS(FRAME_BITS)
    ) u_shift_rx (
        .clk     (Clock_ADC),
        .shift_en(shift_en),
        .din     (sdata),
        .q       (shift_q)
    );

    always_ff @(posedge Clock_ADC or posedge reset_Clock) begin
        if (reset_Clock) begin
            state      <= IDLE;
            cs_n       <= 1'b1;
            sclk       <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            bit_cnt    <= '0;
            phase      <= 1'b0;
            quiet_cnt  <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b1;
                    if (enable) begin
                        state <= START;
                    end
                end
                START: begin
                    cs_n    <= 1'b0;
                    bit_cnt <= '0;
                    phase   <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (!phase) begin
                        sclk  <= 1'b0;
                        phase <= 1'b1;
                    end else begin
                        sclk    <= 1'b1;
                        phase   <= 1'b0;
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    cs_n       <= 1'b1;
                    sclk       <= 1'b1;
                    data_out   <= shift_q[DATA_W-1:0];
                    frame_err  <= |shift_q[FRAME_BITS-1:DATA_W];
                    data_valid <= 1'b1;
                    quiet_cnt  <= '0;
                    state      <= QUIET;
                end
                QUIET: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b1;
                    if (quiet_cnt == QW'(QUIET_CYC - 1)) begin
                        quiet_cnt <= '0;
                        state     <= enable ? START : IDLE;
                    end else begin
                        quiet_cnt <= quiet_cnt + QW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Self-checking bench for adc_serial_reader: behavioural ADC model plus a sample scoreboard.
module tb_adc_serial_reader;

    logic        Clock_ADC;
    logic        reset_Clock;
    logic        enable;
    logic        sdata;
    logic        cs_n;
    logic        sclk;
    logic [11:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;

    logic [15:0] adc_q[$];
    logic [12:0] exp_q[$];
    logic [15:0] cur = 16'h0;
    int          idx = 16;

    adc_serial_reader #(
        .DATA_W    (12),
        .FRAME_BITS(16),
        .QUIET_CYC (2)
    ) dut (
        .Clock_ADC  (Clock_ADC),
        .reset_Clock(reset_Clock),
        .enable     (enable),
        .sdata      (sdata),
        .cs_n       (cs_n),
        .sclk       (sclk),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial Clock_ADC = 1'b0;
    always #5 Clock_ADC = ~Clock_ADC;

    always @(posedge Clock_ADC) cyc++;

    // ADC model: new frame on cs_n fall, next bit presented after each sclk fall.
    always @(negedge cs_n) begin
        if (adc_q.size() > 0) cur = adc_q.pop_front();
        else cur = 16'h0;
        idx = 0;
    end

    always @(negedge sclk) begin
        if (idx < 16) sdata = cur[15 - idx];
        idx++;
    end

    // Scoreboard: every strobe must match the oldest outstanding expected sample.
    always @(negedge Clock_ADC) begin
        logic [12:0] e;
        if (data_valid === 1'b1) begin
            strobe_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: data_out=%h frame_err=%b, no sample expected",
                         data_out, frame_err);
            end else begin
                e = exp_q.pop_front();
                if ({frame_err, data_out} !== e) begin
                    errors++;
                    $display("FAIL sample: got err=%b data=%h, expected err=%b data=%h",
                             frame_err, data_out, e[12], e[11:0]);
                end
            end
        end
    end

    task automatic push_frame(input logic [15:0] f, input bit expect_sample);
        adc_q.push_back(f);
        if (expect_sample) exp_q.push_back({|f[15:12], f[11:0]});
    endtask

    task automatic wait_strobe(input int budget, output bit ok, output int at_cyc);
        ok = 0;
        at_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock_ADC);
            if (data_valid === 1'b1) begin
                ok = 1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock_ADC);
            if (busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_bit(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock_ADC);
            if (cs_n === 1'b0 && idx >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_Clock = 1'b1;
        enable = 1'b0;
        sdata = 1'b0;
        repeat (3) @(negedge Clock_ADC);
        checks++;
        if ({cs_n, sclk, data_out, data_valid, frame_err, busy} !== {1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: cs_n=%b sclk=%b data=%h dv=%b err=%b busy=%b, expected 1 1 000 0 0 0",
                     cs_n, sclk, data_out, data_valid, frame_err, busy);
        end
        reset_Clock = 1'b0;
        @(negedge Clock_ADC);
        checks++;
        if ({cs_n, sclk, busy} !== 3'b110) begin
            errors++;
            $display("FAIL after_release: cs_n=%b sclk=%b busy=%b, expected 1 1 0", cs_n, sclk, busy);
        end
    endtask

    task automatic test_idle;
        int s0;
        int bad;
        s0 = strobe_cnt;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock_ADC);
            if ({cs_n, sclk, busy} !== 3'b110) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_outputs: %0d cycles deviated, required 0", bad);
        end
        checks++;
        if (strobe_cnt != s0) begin
            errors++;
            $display("FAIL idle_strobes: got %0d strobes, required 0", strobe_cnt - s0);
        end
    endtask

    task automatic test_single_frame;
        int c0;
        int t;
        bit ok;
        push_frame(16'h0ABC, 1);
        @(negedge Clock_ADC);
        enable = 1'b1;
        @(negedge Clock_ADC);
        c0 = cyc;
        checks++;
        if (cs_n !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_cycle: cs_n=%b busy=%b, expected 1 1", cs_n, busy);
        end
        @(negedge Clock_ADC);
        checks++;
        if (cs_n !== 1'b0) begin
            errors++;
            $display("FAIL cs_low_latency: cs_n=%b, expected 0", cs_n);
        end
        enable = 1'b0;
        wait_strobe(60, ok, t);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_strobe_timeout: no strobe within 60 cycles");
        end else begin
            checks++;
            if (t - c0 != 34) begin
                errors++;
                $display("FAIL strobe_latency: got %0d cycles, required 34", t - c0);
            end
            checks++;
            if (idx != 16) begin
                errors++;
                $display("FAIL sclk_falls: got %0d, required 16", idx);
            end
            checks++;
            if (data_out !== 12'hABC || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL single_data: got %h err=%b, expected abc err=0", data_out, frame_err);
            end
            @(negedge Clock_ADC);
            checks++;
            if (data_valid !== 1'b0) begin
                errors++;
                $display("FAIL strobe_width: data_valid=%b one cycle later, expected 0", data_valid);
            end
        end
        wait_idle(20, ok);
        checks++;
        if (!ok || cs_n !== 1'b1) begin
            errors++;
            $display("FAIL single_return_idle: ok=%b cs_n=%b, expected 1 1", ok, cs_n);
        end
    endtask

    task automatic test_back_to_back;
        int t1;
        int t2;
        int hi;
        bit ok;
        push_frame(16'h0123, 1);
        push_frame(16'h0FFF, 1);
        @(negedge Clock_ADC);
        enable = 1'b1;
        wait_strobe(60, ok, t1);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_first_timeout: no strobe within 60 cycles");
        end
        hi = 0;
        for (int k = 0; k < 10 && cs_n === 1'b1; k++) begin
            hi++;
            @(negedge Clock_ADC);
        end
        enable = 1'b0;
        checks++;
        if (hi < 2 || cs_n !== 1'b0) begin
            errors++;
            $display("FAIL quiet_gap: cs_n high %0d cycles then cs_n=%b, required >=2 then 0", hi, cs_n);
        end
        wait_strobe(60, ok, t2);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_second_timeout: no strobe within 60 cycles");
        end else begin
            checks++;
            if (t2 - t1 != 36) begin
                errors++;
                $display("FAIL frame_period: got %0d cycles, required 36", t2 - t1);
            end
            checks++;
            if (data_out !== 12'hFFF) begin
                errors++;
                $display("FAIL b2b_second_data: got %h, expected fff", data_out);
            end
        end
        wait_idle(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_idle_timeout: busy still high");
        end
    endtask

    task automatic test_frame_err;
        int t;
        bit ok;
        push_frame(16'h8001, 1);
        push_frame(16'h0001, 1);
        @(negedge Clock_ADC);
        enable = 1'b1;
        wait_strobe(60, ok, t);
        checks++;
        if (!ok || frame_err !== 1'b1 || data_out !== 12'h001) begin
            errors++;
            $display("FAIL err_set: ok=%b err=%b data=%h, expected 1 1 001", ok, frame_err, data_out);
        end
        wait_bit(1, 20, ok);
        enable = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL err_second_start: second frame did not start");
        end
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: frame_err=%b between strobes, expected 1", frame_err);
        end
        wait_strobe(60, ok, t);
        checks++;
        if (!ok || frame_err !== 1'b0 || data_out !== 12'h001) begin
            errors++;
            $display("FAIL err_clear: ok=%b err=%b data=%h, expected 1 0 001", ok, frame_err, data_out);
        end
        wait_idle(20, ok);
    endtask

    task automatic test_enable_drop;
        int s0;
        int t;
        bit ok;
        s0 = strobe_cnt;
        push_frame(16'h0555, 1);
        @(negedge Clock_ADC);
        enable = 1'b1;
        wait_bit(6, 40, ok);
        enable = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drop_reach_bit5: frame did not reach bit 5");
        end
        wait_strobe(60, ok, t);
        checks++;
        if (!ok || data_out !== 12'h555) begin
            errors++;
            $display("FAIL drop_completes: ok=%b data=%h, expected 1 555", ok, data_out);
        end
        repeat (40) @(negedge Clock_ADC);
        checks++;
        if (busy !== 1'b0 || cs_n !== 1'b1 || strobe_cnt != s0 + 1) begin
            errors++;
            $display("FAIL drop_idle: busy=%b cs_n=%b strobes=%0d, expected 0 1 1",
                     busy, cs_n, strobe_cnt - s0);
        end
    endtask

    task automatic test_reset_midframe;
        int s0;
        int t;
        bit ok;
        s0 = strobe_cnt;
        push_frame(16'h0777, 0);
        @(negedge Clock_ADC);
        enable = 1'b1;
        wait_bit(9, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_reach_bit8: frame did not reach bit 8");
        end
        reset_Clock = 1'b1;
        #1;
        checks++;
        if ({cs_n, sclk, data_out, data_valid, busy} !== {1'b1, 1'b1, 12'h000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: cs_n=%b sclk=%b data=%h dv=%b busy=%b, expected 1 1 000 0 0",
                     cs_n, sclk, data_out, data_valid, busy);
        end
        repeat (3) @(negedge Clock_ADC);
        push_frame(16'h0246, 1);
        reset_Clock = 1'b0;
        wait_strobe(60, ok, t);
        enable = 1'b0;
        checks++;
        if (!ok || data_out !== 12'h246 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_frame: ok=%b data=%h err=%b, expected 1 246 0", ok, data_out, frame_err);
        end
        wait_idle(20, ok);
        checks++;
        if (strobe_cnt != s0 + 1) begin
            errors++;
            $display("FAIL abort_no_strobe: got %0d strobes, required 1", strobe_cnt - s0);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_frame();
        test_back_to_back();
        test_frame_err();
        test_enable_drop();
        test_reset_midframe();
        repeat (2) @(negedge Clock_ADC);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_samples: %0d expected samples never strobed, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
